div_restaurador_iter: RTL and testbench

- Iterative restoring divider: WDD-bit dividend by WDV-bit divisor, giving a (WDD-WDV)-bit quotient and a WDV-bit remainder.
- Generalised successor of the fixed 32/16 pipeline divider stages: widths are parametrised, the number of quotient bits per clock is selectable, and signed/unsigned mode is chosen per operation.
- Adds divide-by-zero and overflow detection.
- Sits beside the ALU as a multi-cycle unit with a go/busy/done handshake. One operation is in flight at a time.

---
 rtl/div_restaurador_iter_if.sv | 28 ++
 rtl/div_restaurador_iter.sv | 161 ++++++++++++++++
 tb/tb_div_restaurador_iter.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/div_restaurador_iter_if.sv
// rtl/div_restaurador_iter_if.sv - go/busy/done operand and result bundle for the iterative divider
interface div_restaurador_iter_if #(
  parameter int WDV = 16,
  parameter int WDD = 32
);
  localparam int QW = WDD - WDV;

  logic           go;
  logic           modoSigned;
  logic [WDD-1:0] dividendIn;
  logic [WDV-1:0] divisorIn;
  logic           busy;
  logic           done;
  logic [QW-1:0]  quotientOut;
  logic [WDV-1:0] remainderOut;
  logic           divCero;
  logic           overflow;

  modport master (
    output go, modoSigned, dividendIn, divisorIn,
    input  busy, done, quotientOut, remainderOut, divCero, overflow
  );

  modport slave (
    input  go, modoSigned, dividendIn, divisorIn,
    output busy, done, quotientOut, remainderOut, divCero, overflow
  );
endinterface

// File: rtl/div_restaurador_iter.sv
// rtl/div_restaurador_iter.sv - iterative restoring divider, PASOS quotient bits per clock, signed/unsigned
module div_restaurador_iter #(
  parameter int WDV   = 16,
  parameter int WDD   = 32,
  parameter int PASOS = 1
) (
  input logic                 clk,
  input logic                 reset,
  div_restaurador_iter_if.slave bus
);
  localparam int QW = WDD - WDV;
  localparam int N  = QW / PASOS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST    = CW'(N - 1);
  localparam logic [QW-1:0] QMAXNEG = QW'(1) << (QW - 1);
  localparam logic [QW-1:0] QMAXPOS = QMAXNEG - QW'(1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIX} state_t;

  state_t         state;
  logic [WDD-1:0] opA;
  logic [WDV-1:0] opB;
  logic           sgnR;
  logic [WDV-1:0] magB;
  logic           negA;
  logic           negQ;
  logic           divZeroR;
  logic           preOvfR;
  logic [WDV-1:0] remR;
  // Dividend low bits leave from the top while quotient bits enter at the bottom
  logic [QW-1:0]  dqR;
  logic [CW-1:0]  cnt;

  logic           doneR;
  logic [QW-1:0]  quoR;
  logic [WDV-1:0] remOutR;
  logic           divCeroR;
  logic           ovfR;

  // Operand magnitudes; only meaningful while in PREP
  logic           aNeg;
  logic           bNeg;
  logic [WDD-1:0] magAc;
  logic [WDV-1:0] magBc;
  logic           preOvfC;

  assign aNeg    = sgnR & opA[WDD-1];
  assign bNeg    = sgnR & opB[WDV-1];
  assign magAc   = aNeg ? -opA : opA;
  assign magBc   = bNeg ? -opB : opB;
  assign preOvfC = (magAc[WDD-1 -: WDV] >= magBc);

  // Signed range check of the magnitude quotient; negative results may reach 2^(QW-1)
  logic sgnOvf;
  assign sgnOvf = sgnR & (negQ ? (dqR > QMAXNEG) : (dqR > QMAXPOS));

  // PASOS chained restoring steps; the partial remainder never exceeds the divisor,
  // so the WDV+1-bit shifted value is enough for the trial subtraction
  logic [WDV-1:0] remStep;
  logic [QW-1:0]  dqStep;
  logic [WDV:0]   shifted;
  always_comb begin
    remStep = remR;
    dqStep  = dqR;
    shifted = '0;
    for (int i = 0; i < PASOS; i++) begin
      shifted = {remStep, dqStep[QW-1]};
      if (shifted >= {1'b0, magB}) begin
        remStep = WDV'(shifted - {1'b0, magB});
        dqStep  = {dqStep[QW-2:0], 1'b1};
      end else begin
        remStep = shifted[WDV-1:0];
        dqStep  = {dqStep[QW-2:0], 1'b0};
      end
    end
  end

  // Control FSM: capture, magnitude/error prep, iterate, then publish results with a done pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      opA      <= '0;
      opB      <= '0;
      sgnR     <= 1'b0;
      magB     <= '0;
      negA     <= 1'b0;
      negQ     <= 1'b0;
      divZeroR <= 1'b0;
      preOvfR  <= 1'b0;
      remR     <= '0;
      dqR      <= '0;
      cnt      <= '0;
      doneR    <= 1'b0;
      quoR     <= '0;
      remOutR  <= '0;
      divCeroR <= 1'b0;
      ovfR     <= 1'b0;
    end else begin
      doneR <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go) begin
            opA   <= bus.dividendIn;
            opB   <= bus.divisorIn;
            sgnR  <= bus.modoSigned;
            state <= PREP;
          end
        end
        PREP: begin
          magB     <= magBc;
          negA     <= aNeg;
          negQ     <= aNeg ^ bNeg;
          divZeroR <= (magBc == '0);
          preOvfR  <= preOvfC;
          if ((magBc == '0) || preOvfC) begin
            state <= FIX;
          end else begin
            remR  <= magAc[WDD-1 -: WDV];
            dqR   <= magAc[QW-1:0];
            cnt   <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          remR <= remStep;
          dqR  <= dqStep;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end
        FIX: begin
          doneR <= 1'b1;
          state <= IDLE;
          if (divZeroR) begin
            quoR     <= '1;
            remOutR  <= opA[WDV-1:0];
            divCeroR <= 1'b1;
            ovfR     <= 1'b0;
          end else if (preOvfR || sgnOvf) begin
            quoR     <= '1;
            remOutR  <= '0;
            divCeroR <= 1'b0;
            ovfR     <= 1'b1;
          end else begin
            quoR     <= negQ ? -dqR : dqR;
            remOutR  <= negA ? -remR : remR;
            divCeroR <= 1'b0;
            ovfR     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.done         = doneR;
  assign bus.quotientOut  = quoR;
  assign bus.remainderOut = remOutR;
  assign bus.divCero      = divCeroR;
  assign bus.overflow     = ovfR;
endmodule

// File: tb/tb_div_restaurador_iter.sv
// tb/tb_div_restaurador_iter.sv - directed-vector bench for div_restaurador_iter
module tb_div_restaurador_iter;
  logic clk;
  logic reset;
  int   nCmp;
  int   nFail;

  div_restaurador_iter_if #(.WDV(16), .WDD(32)) b1 ();
  div_restaurador_iter_if #(.WDV(16), .WDD(32)) b2 ();
  div_restaurador_iter_if #(.WDV(16), .WDD(32)) b4 ();

  div_restaurador_iter #(.WDV(16), .WDD(32), .PASOS(1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  div_restaurador_iter #(.WDV(16), .WDD(32), .PASOS(2)) u2 (.clk(clk), .reset(reset), .bus(b2));
  div_restaurador_iter #(.WDV(16), .WDD(32), .PASOS(4)) u4 (.clk(clk), .reset(reset), .bus(b4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue go on b1; returns #1 after e0
  task automatic startOp(input logic sgn, input logic [31:0] a, input logic [15:0] b);
    @(negedge clk);
    b1.go = 1'b1; b1.modoSigned = sgn; b1.dividendIn = a; b1.divisorIn = b;
    @(posedge clk); #1;
    b1.go = 1'b0;
  endtask

  // Count edges until done on b1; busyOk drops if busy was low before done
  task automatic waitDone(output int edges, output bit busyOk);
    edges = 0; busyOk = 1'b1;
    while (edges < 60) begin
      if (!b1.busy) busyOk = 1'b0;
      @(posedge clk); edges++; #1;
      if (b1.done) break;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nCmp++; if (b1.busy !== 1'b0) begin nFail++; $display("FAIL reset_busy got %b want 0", b1.busy); end
    nCmp++; if (b1.done !== 1'b0) begin nFail++; $display("FAIL reset_done got %b want 0", b1.done); end
    nCmp++; if (b1.quotientOut !== 16'h0 || b1.remainderOut !== 16'h0) begin nFail++; $display("FAIL reset_results got q=%h r=%h want 0/0", b1.quotientOut, b1.remainderOut); end
    nCmp++; if (b1.divCero !== 1'b0 || b1.overflow !== 1'b0) begin nFail++; $display("FAIL reset_flags got dc=%b ov=%b want 0/0", b1.divCero, b1.overflow); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_unsigned;
    int e; bit bok;
    startOp(1'b0, 32'd100000, 16'd300);
    waitDone(e, bok);
    nCmp++; if (e !== 18) begin nFail++; $display("FAIL uns_latency got %0d want 18", e); end
    nCmp++; if (bok !== 1'b1) begin nFail++; $display("FAIL uns_busy_during got %b want 1", bok); end
    nCmp++; if (b1.busy !== 1'b0) begin nFail++; $display("FAIL uns_busy_at_done got %b want 0", b1.busy); end
    nCmp++; if (b1.quotientOut !== 16'd333) begin nFail++; $display("FAIL uns_q got %0d want 333", b1.quotientOut); end
    nCmp++; if (b1.remainderOut !== 16'd100) begin nFail++; $display("FAIL uns_r got %0d want 100", b1.remainderOut); end
    nCmp++; if (b1.divCero !== 1'b0 || b1.overflow !== 1'b0) begin nFail++; $display("FAIL uns_flags got dc=%b ov=%b want 0/0", b1.divCero, b1.overflow); end
    @(posedge clk); #1;
    nCmp++; if (b1.done !== 1'b0) begin nFail++; $display("FAIL uns_done_pulse got %b want 0", b1.done); end
    nCmp++; if (b1.quotientOut !== 16'd333) begin nFail++; $display("FAIL uns_q_hold got %0d want 333", b1.quotientOut); end
    startOp(1'b0, 32'd7, 16'd2);
    waitDone(e, bok);
    nCmp++; if (b1.quotientOut !== 16'd3 || b1.remainderOut !== 16'd1) begin nFail++; $display("FAIL uns_7_2 got q=%0d r=%0d want 3/1", b1.quotientOut, b1.remainderOut); end
  endtask

  task automatic test_div_zero;
    int e; bit bok;
    startOp(1'b0, 32'd1234, 16'd0);
    waitDone(e, bok);
    nCmp++; if (e !== 2) begin nFail++; $display("FAIL dz_latency got %0d want 2", e); end
    nCmp++; if (b1.divCero !== 1'b1 || b1.overflow !== 1'b0) begin nFail++; $display("FAIL dz_flags got dc=%b ov=%b want 1/0", b1.divCero, b1.overflow); end
    nCmp++; if (b1.quotientOut !== 16'hFFFF || b1.remainderOut !== 16'h04D2) begin nFail++; $display("FAIL dz_results got q=%h r=%h want ffff/04d2", b1.quotientOut, b1.remainderOut); end
  endtask

  task automatic test_overflow;
    int e; bit bok;
    startOp(1'b0, 32'h0005_0000, 16'd5);
    waitDone(e, bok);
    nCmp++; if (e !== 2) begin nFail++; $display("FAIL ovf_latency got %0d want 2", e); end
    nCmp++; if (b1.overflow !== 1'b1 || b1.divCero !== 1'b0) begin nFail++; $display("FAIL ovf_flags got ov=%b dc=%b want 1/0", b1.overflow, b1.divCero); end
    nCmp++; if (b1.quotientOut !== 16'hFFFF || b1.remainderOut !== 16'h0) begin nFail++; $display("FAIL ovf_results got q=%h r=%h want ffff/0000", b1.quotientOut, b1.remainderOut); end
    startOp(1'b1, 32'h0000_8000, 16'd1);
    waitDone(e, bok);
    nCmp++; if (e !== 18) begin nFail++; $display("FAIL sovf_latency got %0d want 18", e); end
    nCmp++; if (b1.overflow !== 1'b1 || b1.quotientOut !== 16'hFFFF || b1.remainderOut !== 16'h0) begin nFail++; $display("FAIL sovf_results got ov=%b q=%h r=%h want 1/ffff/0000", b1.overflow, b1.quotientOut, b1.remainderOut); end
    startOp(1'b1, 32'hFFFF_8000, 16'd1);
    waitDone(e, bok);
    nCmp++; if (b1.overflow !== 1'b0 || b1.quotientOut !== 16'h8000 || b1.remainderOut !== 16'h0) begin nFail++; $display("FAIL sneg_limit got ov=%b q=%h r=%h want 0/8000/0000", b1.overflow, b1.quotientOut, b1.remainderOut); end
  endtask

  task automatic test_signed;
    int e; bit bok;
    startOp(1'b1, 32'hFFFE_7960, 16'd300);
    waitDone(e, bok);
    nCmp++; if (b1.quotientOut !== 16'hFEB3 || b1.remainderOut !== 16'hFF9C) begin nFail++; $display("FAIL sgn_negA got q=%h r=%h want feb3/ff9c", b1.quotientOut, b1.remainderOut); end
    startOp(1'b1, 32'd100000, 16'hFED4);
    waitDone(e, bok);
    nCmp++; if (b1.quotientOut !== 16'hFEB3 || b1.remainderOut !== 16'h0064) begin nFail++; $display("FAIL sgn_negB got q=%h r=%h want feb3/0064", b1.quotientOut, b1.remainderOut); end
    startOp(1'b1, 32'hFFFF_FFF9, 16'hFFFE);
    waitDone(e, bok);
    nCmp++; if (b1.quotientOut !== 16'h0003 || b1.remainderOut !== 16'hFFFF) begin nFail++; $display("FAIL sgn_bothneg got q=%h r=%h want 0003/ffff", b1.quotientOut, b1.remainderOut); end
  endtask

  task automatic test_pasos;
    int e1s, e2s, e4s;
    e1s = -1; e2s = -1; e4s = -1;
    @(negedge clk);
    b1.go = 1'b1; b1.modoSigned = 1'b0; b1.dividendIn = 32'd100000; b1.divisorIn = 16'd300;
    b2.go = 1'b1; b2.modoSigned = 1'b0; b2.dividendIn = 32'd100000; b2.divisorIn = 16'd300;
    b4.go = 1'b1; b4.modoSigned = 1'b0; b4.dividendIn = 32'd100000; b4.divisorIn = 16'd300;
    @(posedge clk); #1;
    b1.go = 1'b0; b2.go = 1'b0; b4.go = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (b1.done && e1s < 0) e1s = k;
      if (b2.done && e2s < 0) e2s = k;
      if (b4.done && e4s < 0) e4s = k;
      if (e1s >= 0 && e2s >= 0 && e4s >= 0) break;
    end
    nCmp++; if (e4s !== 6) begin nFail++; $display("FAIL p4_latency got %0d want 6", e4s); end
    nCmp++; if (e2s !== 10) begin nFail++; $display("FAIL p2_latency got %0d want 10", e2s); end
    nCmp++; if (e1s !== 18) begin nFail++; $display("FAIL p1_latency got %0d want 18", e1s); end
    nCmp++; if (b4.quotientOut !== 16'd333 || b4.remainderOut !== 16'd100) begin nFail++; $display("FAIL p4_results got q=%0d r=%0d want 333/100", b4.quotientOut, b4.remainderOut); end
    nCmp++; if (b2.quotientOut !== 16'd333 || b2.remainderOut !== 16'd100) begin nFail++; $display("FAIL p2_results got q=%0d r=%0d want 333/100", b2.quotientOut, b2.remainderOut); end
  endtask

  task automatic test_go_while_busy;
    int e; bit bok;
    startOp(1'b0, 32'd100000, 16'd300);
    repeat (4) @(posedge clk);
    @(negedge clk);
    b1.go = 1'b1; b1.dividendIn = 32'd50; b1.divisorIn = 16'd7;
    @(posedge clk); #1;
    b1.go = 1'b0;
    waitDone(e, bok);
    nCmp++; if (e !== 13) begin nFail++; $display("FAIL gob_latency got %0d want 13 after e5", e); end
    nCmp++; if (b1.quotientOut !== 16'd333 || b1.remainderOut !== 16'd100) begin nFail++; $display("FAIL gob_results got q=%0d r=%0d want 333/100", b1.quotientOut, b1.remainderOut); end
    @(posedge clk); #1;
    nCmp++; if (b1.busy !== 1'b0) begin nFail++; $display("FAIL gob_no_restart got %b want 0", b1.busy); end
  endtask

  task automatic test_back_to_back;
    int e; bit bok;
    startOp(1'b0, 32'd100000, 16'd300);
    waitDone(e, bok);
    startOp(1'b0, 32'd7, 16'd2);
    nCmp++; if (b1.busy !== 1'b1 || b1.quotientOut !== 16'd333) begin nFail++; $display("FAIL b2b_start got busy=%b q=%0d want 1/333", b1.busy, b1.quotientOut); end
    waitDone(e, bok);
    nCmp++; if (e !== 18) begin nFail++; $display("FAIL b2b_latency got %0d want 18", e); end
    nCmp++; if (b1.quotientOut !== 16'd3 || b1.remainderOut !== 16'd1) begin nFail++; $display("FAIL b2b_results got q=%0d r=%0d want 3/1", b1.quotientOut, b1.remainderOut); end
  endtask

  task automatic test_reset_mid;
    int e; bit bok; bit sawDone;
    startOp(1'b0, 32'd100000, 16'd300);
    repeat (7) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    nCmp++; if (b1.busy !== 1'b0 || b1.done !== 1'b0) begin nFail++; $display("FAIL rmid_ctrl got busy=%b done=%b want 0/0", b1.busy, b1.done); end
    nCmp++; if (b1.quotientOut !== 16'h0 || b1.remainderOut !== 16'h0 || b1.divCero !== 1'b0 || b1.overflow !== 1'b0) begin nFail++; $display("FAIL rmid_outputs got q=%h r=%h dc=%b ov=%b want zeros", b1.quotientOut, b1.remainderOut, b1.divCero, b1.overflow); end
    @(posedge clk);
    @(negedge clk); reset = 1'b1;
    sawDone = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (b1.done || b1.busy) sawDone = 1'b1;
    end
    nCmp++; if (sawDone !== 1'b0) begin nFail++; $display("FAIL rmid_aborted got activity=%b want 0", sawDone); end
    startOp(1'b0, 32'd7, 16'd2);
    waitDone(e, bok);
    nCmp++; if (e !== 18 || b1.quotientOut !== 16'd3 || b1.remainderOut !== 16'd1) begin nFail++; $display("FAIL rmid_fresh got e=%0d q=%0d r=%0d want 18/3/1", e, b1.quotientOut, b1.remainderOut); end
  endtask

  initial begin
    nCmp = 0; nFail = 0;
    reset = 1'b0;
    b1.go = 1'b0; b1.modoSigned = 1'b0; b1.dividendIn = '0; b1.divisorIn = '0;
    b2.go = 1'b0; b2.modoSigned = 1'b0; b2.dividendIn = '0; b2.divisorIn = '0;
    b4.go = 1'b0; b4.modoSigned = 1'b0; b4.dividendIn = '0; b4.divisorIn = '0;
    test_reset;
    test_unsigned;
    test_div_zero;
    test_overflow;
    test_signed;
    test_pasos;
    test_go_while_busy;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
